soc_tb_top: RTL and testbench

SOC_TB_TOP -- requirements
Module: soc_tb_top

---
 rtl/soc_tb_pkg.sv | 32 +++
 rtl/soc_tb_rx.sv | 100 ++++++++++
 rtl/soc_tb_top.sv | 94 +++++++++
 tb/tb_soc_tb_top.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_tb_pkg.sv
// Shared frame geometry, FSM state types and frame builder
// for the point-to-point temperature node.
package soc_tb_pkg;

    localparam int FRAME_BITS = 17;
    localparam int ID_W       = 4;
    localparam int DATA_W     = 10;

    typedef enum logic [1:0] {
        TX_IDLE_WAIT,
        TX_SEND,
        TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_CHECK,
        RX_DONE,
        RX_ERR
    } rx_state_t;

    // start, id, data, even parity, stop
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ID_W-1:0]   id,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, id, data, ^{id, data}, 1'b0};
    endfunction

endpackage

// File: rtl/soc_tb_rx.sv
// Frame receiver: input synchronizer, mid-bit sampler and
// frame checker. Accepts at most one frame per reset.
module soc_tb_rx
    import soc_tb_pkg::*;
#(
    parameter logic [ID_W-1:0] ID         = '0,
    parameter int              BIT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic antena_in,
    output logic rx_done,
    output logic rx_err
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 2);

    logic                  sync1;
    logic                  sync2;
    logic                  prev;
    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [3:0]            nbits;
    logic [FRAME_BITS-2:0] sh;

    logic [ID_W-1:0]   rx_id;
    logic [DATA_W-1:0] rx_data;
    logic              rx_par;
    logic              rx_stop;
    logic              bad;

    // sh holds everything after the start bit and keeps the data once done
    assign rx_id   = sh[15:12];
    assign rx_data = sh[11:2];
    assign rx_par  = sh[1];
    assign rx_stop = sh[0];
    assign bad     = (^{rx_id, rx_data} != rx_par) || rx_stop || (rx_id == ID);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            state   <= RX_IDLE;
            cnt     <= '0;
            nbits   <= '0;
            sh      <= '0;
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            sync1 <= antena_in;
            sync2 <= sync1;
            prev  <= sync2;
            unique case (state)
                RX_IDLE: begin
                    if (sync2 && !prev) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        nbits <= '0;
                        state <= sync2 ? RX_BITS : RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        sh    <= {sh[FRAME_BITS-3:0], sync2};
                        nbits <= nbits + 1'b1;
                        if (nbits == LAST_BIT)
                            state <= RX_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_CHECK: begin
                    if (bad) begin
                        state  <= RX_ERR;
                        rx_err <= 1'b1;
                    end else begin
                        state   <= RX_DONE;
                        rx_done <= 1'b1;
                    end
                end
                RX_DONE, RX_ERR: begin
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/soc_tb_top.sv
// Temperature node: sends one frame after a startup delay,
// receives one frame from its peer and reports finish/trap.
module soc_tb_top
    import soc_tb_pkg::*;
#(
    parameter logic [ID_W-1:0] ID         = '0,
    parameter int              BIT_CYCLES = 16,
    parameter int              TX_DELAY   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_out,
    input  logic              antena_in,
    output logic              antena_out,
    output logic              trap,
    output logic              finish
);

    localparam int DW = $clog2(TX_DELAY + 1);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [DW-1:0] DLY_LAST = DW'(TX_DELAY - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS - 1);

    tx_state_t             tx_state;
    logic [DW-1:0]         dly;
    logic [CW-1:0]         bcnt;
    logic [4:0]            nbits;
    logic [FRAME_BITS-1:0] sh;
    logic                  rx_done;
    logic                  rx_err;

    soc_tb_rx #(
        .ID         (ID),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .antena_in (antena_in),
        .rx_done   (rx_done),
        .rx_err    (rx_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= TX_IDLE_WAIT;
            dly        <= '0;
            bcnt       <= '0;
            nbits      <= '0;
            sh         <= '0;
            antena_out <= 1'b0;
        end else begin
            unique case (tx_state)
                TX_IDLE_WAIT: begin
                    if (dly == DLY_LAST) begin
                        sh       <= build_frame(ID, adc_out);
                        bcnt     <= '0;
                        nbits    <= '0;
                        tx_state <= TX_SEND;
                    end else begin
                        dly <= dly + 1'b1;
                    end
                end
                TX_SEND: begin
                    antena_out <= sh[FRAME_BITS-1];
                    if (bcnt == BIT_LAST) begin
                        bcnt  <= '0;
                        sh    <= {sh[FRAME_BITS-2:0], 1'b0};
                        nbits <= nbits + 1'b1;
                        if (nbits == LAST_BIT)
                            tx_state <= TX_DONE;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                TX_DONE: antena_out <= 1'b0;
                default: tx_state <= TX_IDLE_WAIT;
            endcase
        end
    end

    // trap blocks finish for good, so the two can never be high together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap   <= 1'b0;
            finish <= 1'b0;
        end else begin
            trap   <= trap | rx_err;
            finish <= (finish | ((tx_state == TX_DONE) & rx_done))
                      & ~trap & ~rx_err;
        end
    end

endmodule

// File: tb/tb_soc_tb_top.sv
// Two cross-connected nodes; node 0 input can be switched to
// a bench-driven line for hand-built and randomized frames.
module tb_soc_tb_top;

    localparam int B   = 16;
    localparam int DLY = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] adc0 = 10'h04F;
    logic [9:0] adc1 = 10'h012;
    logic       hand = 1'b0;
    logic       tb_line = 1'b0;
    logic       in0, out0, out1;
    logic       trap0, trap1, fin0, fin1;
    int         cyc;
    int         n_checks = 0;
    int         n_fail = 0;

    assign in0 = hand ? tb_line : out1;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;

    soc_tb_top #(.ID(4'd0), .BIT_CYCLES(B), .TX_DELAY(DLY)) u0 (
        .clk(clk), .reset(reset), .adc_out(adc0), .antena_in(in0),
        .antena_out(out0), .trap(trap0), .finish(fin0)
    );

    soc_tb_top #(.ID(4'd1), .BIT_CYCLES(B), .TX_DELAY(DLY)) u1 (
        .clk(clk), .reset(reset), .adc_out(adc1), .antena_in(out0),
        .antena_out(out1), .trap(trap1), .finish(fin1)
    );

    // reference frame: computed from field values and a ones count
    function automatic logic [16:0] mk(input int id, input int data,
                                       input bit flip, input bit bstop);
        int  ones;
        logic par;
        ones = $countones(id[3:0]) + $countones(data[9:0]);
        par  = logic'(ones % 2) ^ flip;
        return {1'b1, id[3:0], data[9:0], par, bstop};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send_frame(input logic [16:0] f);
        for (int i = 16; i >= 0; i--) begin
            tb_line = f[i];
            repeat (B) @(negedge clk);
        end
        tb_line = 1'b0;
    endtask

    task automatic test_reset();
        hand = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out0 !== 1'b0) begin n_fail++; $display("FAIL rst_out0 got %b want 0", out0); end
        n_checks++; if (out1 !== 1'b0) begin n_fail++; $display("FAIL rst_out1 got %b want 0", out1); end
        n_checks++; if (trap0 !== 1'b0) begin n_fail++; $display("FAIL rst_trap0 got %b want 0", trap0); end
        n_checks++; if (trap1 !== 1'b0) begin n_fail++; $display("FAIL rst_trap1 got %b want 0", trap1); end
        n_checks++; if (fin0 !== 1'b0) begin n_fail++; $display("FAIL rst_fin0 got %b want 0", fin0); end
        n_checks++; if (fin1 !== 1'b0) begin n_fail++; $display("FAIL rst_fin1 got %b want 0", fin1); end
    endtask

    task automatic test_pair();
        logic [16:0] f0, f1;
        hand = 1'b0;
        adc0 = 10'h04F;
        adc1 = 10'h012;
        f0 = mk(0, 'h04F, 1'b0, 1'b0);
        f1 = mk(1, 'h012, 1'b0, 1'b0);
        do_reset();
        wait_until(DLY);
        n_checks++; if (out0 !== 1'b0) begin n_fail++; $display("FAIL pair_early0 got %b want 0", out0); end
        n_checks++; if (out1 !== 1'b0) begin n_fail++; $display("FAIL pair_early1 got %b want 0", out1); end
        wait_until(DLY + 1);
        n_checks++; if (out0 !== 1'b1) begin n_fail++; $display("FAIL pair_rise0 got %b want 1", out0); end
        n_checks++; if (out1 !== 1'b1) begin n_fail++; $display("FAIL pair_rise1 got %b want 1", out1); end
        for (int i = 0; i < 17; i++) begin
            wait_until(DLY + 1 + B * i + B / 2);
            n_checks++;
            if (out0 !== f0[16-i]) begin
                n_fail++; $display("FAIL pair_bit0[%0d] got %b want %b", i, out0, f0[16-i]);
            end
            n_checks++;
            if (out1 !== f1[16-i]) begin
                n_fail++; $display("FAIL pair_bit1[%0d] got %b want %b", i, out1, f1[16-i]);
            end
        end
        wait_until(300);
        n_checks++; if (fin0 !== 1'b0) begin n_fail++; $display("FAIL pair_fin_early got %b want 0", fin0); end
        wait_until(DLY + 1 + 17 * B + 4);
        n_checks++; if (fin0 !== 1'b1) begin n_fail++; $display("FAIL pair_fin0 got %b want 1", fin0); end
        n_checks++; if (fin1 !== 1'b1) begin n_fail++; $display("FAIL pair_fin1 got %b want 1", fin1); end
        n_checks++; if (trap0 !== 1'b0) begin n_fail++; $display("FAIL pair_trap0 got %b want 0", trap0); end
        n_checks++; if (trap1 !== 1'b0) begin n_fail++; $display("FAIL pair_trap1 got %b want 0", trap1); end
        n_checks++; if (out0 !== 1'b0) begin n_fail++; $display("FAIL pair_idle0 got %b want 0", out0); end
    endtask

    task automatic run_hand(input string nm, input int id, input int data,
                            input bit flip, input bit bstop, input int start);
        logic [16:0] f;
        logic exp_err;
        f = mk(id, data, flip, bstop);
        exp_err = flip || bstop || (id[3:0] == 4'd0);
        hand = 1'b1;
        tb_line = 1'b0;
        do_reset();
        wait_until(start);
        send_frame(f);
        repeat (6) @(negedge clk);
        n_checks++;
        if (trap0 !== exp_err) begin
            n_fail++; $display("FAIL %s_trap got %b want %b", nm, trap0, exp_err);
        end
        n_checks++;
        if (fin0 !== 1'b0) begin
            n_fail++; $display("FAIL %s_fin_early got %b want 0", nm, fin0);
        end
        wait_until(345);
        n_checks++;
        if (trap0 !== exp_err) begin
            n_fail++; $display("FAIL %s_trap_end got %b want %b", nm, trap0, exp_err);
        end
        n_checks++;
        if (fin0 !== !exp_err) begin
            n_fail++; $display("FAIL %s_fin got %b want %b", nm, fin0, !exp_err);
        end
    endtask

    task automatic test_bad_parity();
        run_hand("badpar", 1, 'h3FF, 1'b1, 1'b0, 8);
    endtask

    task automatic test_own_id();
        run_hand("ownid", 0, int'($urandom_range(0, 1023)), 1'b0, 1'b0, 12);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int  id, data, kind;
            id   = int'($urandom_range(0, 15));
            data = int'($urandom_range(0, 1023));
            kind = int'($urandom_range(0, 3));
            run_hand("rand", id, data, kind == 1, kind == 2,
                     5 + int'($urandom_range(0, 20)));
        end
    endtask

    task automatic test_glitch();
        hand = 1'b1;
        tb_line = 1'b0;
        do_reset();
        wait_until(10);
        tb_line = 1'b1;
        repeat (3) @(negedge clk);
        tb_line = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (trap0 !== 1'b0) begin n_fail++; $display("FAIL glitch_trap got %b want 0", trap0); end
        send_frame(mk(int'($urandom_range(1, 15)), int'($urandom_range(0, 1023)), 1'b0, 1'b0));
        wait_until(DLY + 17 * B);
        n_checks++; if (fin0 !== 1'b0) begin n_fail++; $display("FAIL glitch_fin_pre got %b want 0", fin0); end
        wait_until(DLY + 17 * B + 1);
        n_checks++; if (fin0 !== 1'b1) begin n_fail++; $display("FAIL glitch_fin got %b want 1", fin0); end
        n_checks++; if (trap0 !== 1'b0) begin n_fail++; $display("FAIL glitch_trap_end got %b want 0", trap0); end
    endtask

    task automatic test_mid_reset();
        logic [16:0] f0;
        hand = 1'b0;
        do_reset();
        wait_until(DLY + 1 + 100);
        reset = 1'b0;
        adc0 = 10'($urandom);
        adc1 = 10'($urandom);
        f0 = mk(0, int'(adc0), 1'b0, 1'b0);
        #1;
        n_checks++; if (out0 !== 1'b0) begin n_fail++; $display("FAIL midrst_out0 got %b want 0", out0); end
        n_checks++; if (out1 !== 1'b0) begin n_fail++; $display("FAIL midrst_out1 got %b want 0", out1); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_until(DLY);
        n_checks++; if (out0 !== 1'b0) begin n_fail++; $display("FAIL midrst_early got %b want 0", out0); end
        wait_until(DLY + 1);
        n_checks++; if (out0 !== 1'b1) begin n_fail++; $display("FAIL midrst_rise got %b want 1", out0); end
        for (int i = 1; i < 17; i++) begin
            wait_until(DLY + 1 + B * i + B / 2);
            n_checks++;
            if (out0 !== f0[16-i]) begin
                n_fail++; $display("FAIL midrst_bit[%0d] got %b want %b", i, out0, f0[16-i]);
            end
        end
        wait_until(DLY + 1 + 17 * B + 4);
        n_checks++; if (fin0 !== 1'b1) begin n_fail++; $display("FAIL midrst_fin0 got %b want 1", fin0); end
        n_checks++; if (fin1 !== 1'b1) begin n_fail++; $display("FAIL midrst_fin1 got %b want 1", fin1); end
        n_checks++; if (trap0 !== 1'b0) begin n_fail++; $display("FAIL midrst_trap got %b want 0", trap0); end
    endtask

    task automatic test_back_to_back();
        int id;
        id = int'($urandom_range(1, 15));
        hand = 1'b1;
        tb_line = 1'b0;
        do_reset();
        wait_until(10);
        send_frame(mk(id, int'($urandom_range(0, 1023)), 1'b0, 1'b0));
        repeat (20) @(negedge clk);
        send_frame(mk(id, int'($urandom_range(0, 1023)), 1'b1, 1'b0));
        repeat (10) @(negedge clk);
        n_checks++; if (fin0 !== 1'b1) begin n_fail++; $display("FAIL b2b_fin got %b want 1", fin0); end
        n_checks++; if (trap0 !== 1'b0) begin n_fail++; $display("FAIL b2b_trap got %b want 0", trap0); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_bad_parity();
        test_own_id();
        test_glitch();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
